imem_fetch_ctrl: RTL
====================

// Module: imem_fetch_ctrl
// PURPOSE
//  Instruction-side memory controller that sits directly upstream of the fetch stage.
//  Takes the fetch stage's combinational next_pc and issues word fetches on a req/gnt/rvalid bus (ITCM or bus bridge).
//  Returns instr_read_data/instr_read_data_valid for the registered pc, and holds a 1-entry tagged line buffer.
//  The buffer re-serves a held pc (dec stall, keep_pc) without a new bus access.
// PARAMETERS
//  ADDR_WIDTH   32  address width (matches `ADDR_WIDTH)
//  INSTR_WIDTH  32  instruction width (matches `INSTR_WIDTH)
// PORTS
//  cpu_clk                in   1            core clock
//  cpu_rstn               in   1            async active-low reset
//  next_pc                in   ADDR_WIDTH   fetch's next pc (combinational, this cycle)
//  pc                     in   ADDR_WIDTH   fetch's registered pc
//  fence_i                in   1            invalidate line buffer
//  instr_read_data_valid  out  1            instr_read_data is the word at pc
//  instr_read_data        out  INSTR_WIDTH  instruction word
//  instr_fetch_err        out  1            bus error for the word at pc
//  ib_req                 out  1            bus request
//  ib_addr                out  ADDR_WIDTH   word-aligned bus address
//  ib_gnt                 in   1            request accepted this cycle
//  ib_rvalid              in   1            response valid
//  ib_rdata               in   INSTR_WIDTH  response data
//  ib_err                 in   1            response error (qualified by ib_rvalid)
// BEHAVIOUR
//  - Reset: cpu_rstn async active-low, clock cpu_clk.
//    State IDLE; buf_valid=0; buf_addr/buf_data/out_addr=0; rst_done=0.
//    rst_done is set 1 cycle after reset release.
//    ib_req=0 while rst_done=0; all outputs 0 during reset.
//  - Alignment: np = {next_pc[A-1:2],2'b00}; cur = {pc[A-1:2],2'b00}.
//    Tags compare word addresses only. pc[1:0] is ignored here (fetch flags misalignment).
//  - FSM:
//    IDLE     - no request outstanding.
//    WAIT_GNT - ib_req=1, ib_addr = req_addr_r held stable until gnt.
//    WAIT_RSP - one request granted, response pending; out_addr = its word address.
//  - At most one outstanding request. A new request may issue in the same cycle ib_rvalid arrives (back-to-back).
//  - covered(np) = (buf_valid && buf_addr==np) || (WAIT_RSP && out_addr==np).
//  - can_issue = rst_done && (IDLE || (WAIT_RSP && ib_rvalid)).
//    ib_req = can_issue && !covered(np), or 1 in WAIT_GNT.
//  - ib_addr = np when issuing from IDLE/WAIT_RSP; req_addr_r in WAIT_GNT.
//  - Transitions:
//    IDLE/WAIT_RSP(+rvalid) issuing & gnt  -> WAIT_RSP, out_addr <= np.
//    issuing & !gnt                        -> WAIT_GNT, req_addr_r <= np.
//    WAIT_GNT & gnt                        -> WAIT_RSP, out_addr <= req_addr_r.
//    WAIT_RSP & rvalid & no issue          -> IDLE.
//  - If next_pc changes while in WAIT_GNT, ib_addr does not change.
//    The stale word is fetched, fails the tag check, and np is requested afterwards.
//  - Response capture: on ib_rvalid, buf_addr <= out_addr, buf_data <= ib_rdata, buf_err <= ib_err, buf_valid <= 1.
//    Capture happens regardless of a pc match.
//  - Output selection (combinational, zero added latency):
//    hit_rsp = ib_rvalid && out_addr==cur -> ib_rdata/ib_err.
//    else hit_buf = buf_valid && buf_addr==cur -> buf_data/buf_err.
//    instr_read_data_valid = hit_rsp || hit_buf.
//    instr_read_data = 0 when not valid.
//    instr_fetch_err = valid && selected err.
//  - Zero-wait bus: cycle t next_pc=A, gnt=1; cycle t+1 pc=A, rvalid -> valid at t+1. Sustained 1 instr/cycle.
//  - fence_i: buf_valid <= 0 next cycle. Has priority over a same-cycle capture (the capture is dropped).
//    Does not cancel an outstanding request; that response is captured normally.
//  - Errored words are buffered like data.
//    A held pc keeps reporting instr_fetch_err until pc changes or fence_i.
//  - Reset mid-transaction: FSM to IDLE immediately. Any late ib_rvalid while IDLE is ignored (no capture).
// TESTING
//  1. Zero-wait stream 0x100,0x104,0x108: gnt=1 every cycle, rvalid 1 cycle later ->
//     ib_req each cycle; valid=1 on the 3 following cycles; data matches.
//  2. Held pc 0x200 for 3 cycles (next_pc=pc) after one fetch ->
//     single ib_req; valid=1 all 3 cycles from the buffer.
//  3. gnt low 2 cycles for 0x300; next_pc switches to 0x400 meanwhile ->
//     ib_addr stays 0x300 until gnt; then 0x400 requested; valid only for pc=0x400.
//  4. Response for 0x500 arrives with ib_err=1, pc=0x500 ->
//     valid=1, instr_fetch_err=1; next pc 0x504 fetched cleanly -> err=0.
//  5. fence_i with buffer holding 0x600 and pc held at 0x600 ->
//     valid drops next cycle; new ib_req to 0x600 issued.
//  6. Assert cpu_rstn=0 while in WAIT_RSP ->
//     outputs 0; after release, ib_req stays 0 for 1 cycle; first fetch uses next_pc=boot_addr.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: instruction bus request/grant/response bundle
interface imem_fetch_ctrl_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic                   req;
    logic [ADDR_WIDTH-1:0]  addr;
    logic                   gnt;
    logic                   rvalid;
    logic [INSTR_WIDTH-1:0] rdata;
    logic                   err;

    modport master (output req, addr, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch-side bus controller with a 1-entry tagged line buffer
module imem_fetch_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    input  logic [ADDR_WIDTH-1:0]  pc,
    input  logic                   fence_i,
    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    output logic                   instr_fetch_err,
    imem_fetch_ctrl_if.master      ib
);
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_e;

    state_e                 state_q, state_d;
    logic                   rst_done_q, rst_done_d;
    logic                   buf_valid_q, buf_valid_d;
    logic                   buf_err_q, buf_err_d;
    logic [ADDR_WIDTH-1:0]  buf_addr_q, buf_addr_d;
    logic [INSTR_WIDTH-1:0] buf_data_q, buf_data_d;
    logic [ADDR_WIDTH-1:0]  out_addr_q, out_addr_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;

    logic [ADDR_WIDTH-1:0]  np, cur;
    logic                   capture, covered, can_issue, issue, hit_rsp, hit_buf;
    logic                   unused_low_bits;

    // Byte offsets are irrelevant here; fetch reports misalignment itself.
    assign np              = {next_pc[ADDR_WIDTH-1:2], 2'b00};
    assign cur             = {pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_low_bits = ^{next_pc[1:0], pc[1:0]};

    // A response is only meaningful while one is outstanding; stray rvalid after reset is dropped.
    assign capture   = state_q == WAIT_RSP && ib.rvalid;
    assign covered   = (buf_valid_q && buf_addr_q == np) || (state_q == WAIT_RSP && out_addr_q == np);
    assign can_issue = rst_done_q && (state_q == IDLE || capture);
    assign issue     = can_issue && !covered;

    // State register
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // Next state: a new issue wins over retiring to IDLE on the response cycle
    always_comb begin
        state_d = state_q;
        if (issue)                              state_d = ib.gnt ? WAIT_RSP : WAIT_GNT;
        else if (state_q == WAIT_GNT && ib.gnt) state_d = WAIT_RSP;
        else if (capture)                       state_d = IDLE;
    end

    // Bus outputs: the address is frozen while waiting for grant even if next_pc moves
    always_comb begin
        ib.req  = issue || state_q == WAIT_GNT;
        ib.addr = state_q == WAIT_GNT ? req_addr_q : (issue ? np : '0);
    end

    // Datapath next values; fence_i overrides a same-cycle capture
    always_comb begin
        out_addr_d  = issue && ib.gnt ? np : (state_q == WAIT_GNT && ib.gnt ? req_addr_q : out_addr_q);
        req_addr_d  = issue && !ib.gnt ? np : req_addr_q;
        buf_valid_d = !fence_i && (capture || buf_valid_q);
        buf_addr_d  = capture ? out_addr_q : buf_addr_q;
        buf_data_d  = capture ? ib.rdata : buf_data_q;
        buf_err_d   = capture ? ib.err : buf_err_q;
        rst_done_d  = 1'b1;
    end

    // Datapath registers
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            rst_done_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_err_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            out_addr_q  <= '0;
            req_addr_q  <= '0;
        end else begin
            rst_done_q  <= rst_done_d;
            buf_valid_q <= buf_valid_d;
            buf_err_q   <= buf_err_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            out_addr_q  <= out_addr_d;
            req_addr_q  <= req_addr_d;
        end
    end

    assign hit_rsp = capture && out_addr_q == cur;
    assign hit_buf = buf_valid_q && buf_addr_q == cur;

    // Read-data select: live response bypasses the buffer for zero added latency
    always_comb begin
        instr_read_data_valid = hit_rsp || hit_buf;
        instr_read_data       = hit_rsp ? ib.rdata : (hit_buf ? buf_data_q : '0);
        instr_fetch_err       = hit_rsp ? ib.err : (hit_buf && buf_err_q);
    end
endmodule
